// File: rtl/uart_rx_engine_if.sv
// Peripheral-bus side of the UART receiver: status/data register pair plus the
// one-cycle acknowledge. The bus is the master, the receiver engine the slave.
interface uart_rx_engine_if;
   logic       rx_ack;
   logic [7:0] rx_data;
   logic       rx_status;
   logic       overrun;
   logic       frame_err;
   logic       rx_busy;

   modport master (
      output rx_ack,
      input  rx_data, rx_status, overrun, frame_err, rx_busy
   );

   modport slave (
      input  rx_ack,
      output rx_data, rx_status, overrun, frame_err, rx_busy
   );
endinterface

// File: rtl/uart_rx_engine.sv
// 8-bit LSB-first UART receiver with 16x oversampling and a bus status/data pair.
// Define UART_RX_PARITY_EN to expect one even-parity bit between D7 and the stop bit.
module uart_rx_engine #(
   parameter int CLK_DIV = 651,
   parameter int DIV_W   = 10
) (
   input  logic            sysclk,
   input  logic            reset,
   input  logic            UART_RX,
   uart_rx_engine_if.slave bus
);

`ifdef UART_RX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;
`else
   typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
`endif

   logic [1:0]       sync_q;
   logic             rx_s;
   logic [DIV_W-1:0] div_cnt;
   logic             tick;
   state_t           state;
   logic [3:0]       os;
   logic [2:0]       bit_idx;
   logic [7:0]       shift_q;
`ifdef UART_RX_PARITY_EN
   logic             par_ok;
`endif

   // Two-flop synchronizer; idle-high reset keeps a false start edge out of reset.
   always_ff @(posedge sysclk or negedge reset) begin
      if (!reset) begin
         sync_q <= 2'b11;
      end else begin
         sync_q <= {sync_q[0], UART_RX};
      end
   end

   assign rx_s = sync_q[1];

   // Free-running oversample divider, not re-phased on the start edge.
   always_ff @(posedge sysclk or negedge reset) begin
      if (!reset) begin
         div_cnt <= '0;
      end else if (div_cnt == DIV_W'(CLK_DIV - 1)) begin
         div_cnt <= '0;
      end else begin
         div_cnt <= div_cnt + DIV_W'(1);
      end
   end

   assign tick = (div_cnt == DIV_W'(CLK_DIV - 1));

   always_ff @(posedge sysclk or negedge reset) begin
      if (!reset) begin
         state         <= IDLE;
         os            <= '0;
         bit_idx       <= '0;
         shift_q       <= '0;
`ifdef UART_RX_PARITY_EN
         par_ok        <= 1'b0;
`endif
         bus.rx_data   <= '0;
         bus.rx_status <= 1'b0;
         bus.overrun   <= 1'b0;
         bus.frame_err <= 1'b0;
         bus.rx_busy   <= 1'b0;
      end else begin
         // NOTE: the ack clear comes first; a later non-blocking assignment to the
         // same register in this block wins, so commit and frame-error set override it.
         if (bus.rx_ack) begin
            bus.rx_status <= 1'b0;
            bus.overrun   <= 1'b0;
            bus.frame_err <= 1'b0;
         end

         if (tick) begin
            case (state)
               IDLE: begin
                  if (!rx_s) begin
                     os          <= '0;
                     state       <= START;
                     bus.rx_busy <= 1'b1;
                  end
               end

               START: begin
                  if (os == 4'd7) begin
                     if (rx_s) begin
                        state       <= IDLE;
                        bus.rx_busy <= 1'b0;
                     end else begin
                        os      <= '0;
                        bit_idx <= '0;
                        state   <= DATA;
                     end
                  end else begin
                     os <= os + 4'd1;
                  end
               end

               DATA: begin
                  if (os == 4'd15) begin
                     shift_q[bit_idx] <= rx_s;
                     os               <= '0;
                     bit_idx          <= bit_idx + 3'd1;
                     if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state <= PARITY;
`else
                        state <= STOP;
`endif
                     end
                  end else begin
                     os <= os + 4'd1;
                  end
               end

`ifdef UART_RX_PARITY_EN
               PARITY: begin
                  if (os == 4'd15) begin
                     // Even parity: data bits plus parity bit have an even count of ones.
                     par_ok <= ~(^{shift_q, rx_s});
                     os     <= '0;
                     state  <= STOP;
                  end else begin
                     os <= os + 4'd1;
                  end
               end
`endif

               STOP: begin
                  if (os == 4'd15) begin
                     if (!rx_s) begin
                        bus.frame_err <= 1'b1;
                        state         <= BREAK;
                     end else begin
                        state       <= IDLE;
                        bus.rx_busy <= 1'b0;
`ifdef UART_RX_PARITY_EN
                        if (!par_ok) begin
                           bus.frame_err <= 1'b1;
                        end else begin
                           bus.rx_data   <= shift_q;
                           bus.rx_status <= 1'b1;
                           if (bus.rx_status && !bus.rx_ack) bus.overrun <= 1'b1;
                        end
`else
                        bus.rx_data   <= shift_q;
                        bus.rx_status <= 1'b1;
                        if (bus.rx_status && !bus.rx_ack) bus.overrun <= 1'b1;
`endif
                     end
                  end else begin
                     os <= os + 4'd1;
                  end
               end

               // A held-low line stays here, so it reports a single frame error.
               BREAK: begin
                  if (rx_s) begin
                     state       <= IDLE;
                     bus.rx_busy <= 1'b0;
                  end
               end

               default: begin
                  state       <= IDLE;
                  bus.rx_busy <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule
